// File: rtl/sigdelay_line.sv
// sigdelay_line: sample-strobed programmable delay line over a dual-port RAM.
// Define SIGDELAY_ECHO_EN to mix x[n] with the attenuated delayed sample.
module sigdelay_line #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int ECHO_SHIFT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     delay_load,
  input  logic [ADDRESS_WIDTH-1:0] delay_in,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     primed,
  output logic [ADDRESS_WIDTH-1:0] delay_active,
  output logic [1:0]               state
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] MAX_DELAY = (AW + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t cur;
  state_t nxt;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] x_q;
  logic [DW-1:0] delayed;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] fill_count;
  logic [AW-1:0] delay_r;
  logic [AW-1:0] delay_clamped;
  logic [AW:0]   delay_req;
  logic          enough;
  logic          take;
  logic          hit_q;
  logic          byp_q;

  assign delay_req     = {1'b0, delay_in};
  assign delay_clamped = (delay_req > MAX_DELAY) ?
                         MAX_DELAY[AW-1:0] : delay_in;

  assign enough  = fill_count >= delay_r;
  // A flushed strobe sees an empty history, so only delay 0 passes.
  assign take    = flush ? (delay_r == '0) : enough;
  assign primed  = (fill_count != '0) && enough;
  assign rd_addr = wr_addr - delay_r;

  assign delay_active = delay_r;
  assign state        = cur;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_addr] <= in_data;
      rd_q         <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr    <= '0;
      fill_count <= '0;
      delay_r    <= '0;
      out_valid  <= 1'b0;
      x_q        <= '0;
      hit_q      <= 1'b0;
      byp_q      <= 1'b0;
      cur        <= EMPTY;
    end else begin
      out_valid <= in_valid;
      cur       <= nxt;
      if (delay_load) begin
        delay_r <= delay_clamped;
      end
      if (in_valid) begin
        wr_addr <= wr_addr + 1'b1;
        x_q     <= in_data;
        hit_q   <= take;
        byp_q   <= (delay_r == '0);
      end
      if (flush) begin
        fill_count <= in_valid ? AW'(1) : '0;
      end else if (in_valid && fill_count != '1) begin
        fill_count <= fill_count + 1'b1;
      end
    end
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      EMPTY: begin
        if (in_valid) nxt = FILLING;
      end
      FILLING: begin
        if (primed) nxt = RUN;
      end
      RUN: begin
        if (delay_load && delay_clamped > fill_count) nxt = FILLING;
      end
      default: nxt = EMPTY;
    endcase
    if (flush) nxt = EMPTY;
  end

  // Delay 0 takes the registered input; the RAM word is never used then.
  assign delayed = !hit_q ? '0 : (byp_q ? x_q : rd_q);

`ifdef SIGDELAY_ECHO_EN
  logic signed [DW-1:0] dsh;
  logic signed [DW:0]   sum;

  always_comb begin
    dsh      = $signed(delayed) >>> ECHO_SHIFT;
    sum      = $signed({x_q[DW-1], x_q}) + $signed({dsh[DW-1], dsh});
    out_data = sum[DW-1:0];
    if (sum[DW] != sum[DW-1]) begin
      out_data = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign out_data = delayed;
`endif

endmodule

// File: tb/tb_sigdelay_line.sv
// tb_sigdelay_line: directed stimulus with a queue-based reference model.
// Checks every output cycle plus hand-computed literal expectations.
module tb_sigdelay_line;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       delay_load;
  logic [7:0] delay_in;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       primed;
  logic [7:0] delay_active;
  logic [1:0] state;

  int pass_cnt = 0;
  int total_cnt = 0;

  sigdelay_line #(
    .DATA_WIDTH   (8),
    .ADDRESS_WIDTH(8),
    .ECHO_SHIFT   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .delay_load  (delay_load),
    .delay_in    (delay_in),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .primed      (primed),
    .delay_active(delay_active),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model: history of samples since reset, count since flush.
  logic [7:0] xs[$];
  logic [7:0] outs[$];
  bit         m_valid;
  logic [7:0] m_data;
  int         m_cnt;
  int         m_d;

  initial begin
    int eff;
    bit hit;
    logic [7:0] dsamp;
    m_valid = 0; m_data = 0; m_cnt = 0; m_d = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_valid = 0; m_data = 0; m_cnt = 0; m_d = 0;
        xs.delete();
      end else begin
        m_valid = in_valid;
        if (in_valid) begin
          eff = flush ? 0 : m_cnt;
          hit = (m_d == 0) || (eff >= m_d);
          if (m_d == 0) dsamp = in_data;
          else dsamp = hit ? xs[xs.size() - m_d] : 8'd0;
`ifdef SIGDELAY_ECHO_EN
          m_data = 8'(sat8(int'($signed(in_data)) +
                           (int'($signed(dsamp)) >>> 1)));
`else
          m_data = dsamp;
`endif
          xs.push_back(in_data);
          m_cnt = flush ? 1 : m_cnt + 1;
        end else if (flush) begin
          m_cnt = 0;
        end
        if (delay_load) m_d = int'(delay_in);
      end
    end
  end

  initial begin
    int sc;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sc = (m_cnt > 255) ? 255 : m_cnt;
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) chk("out_data", int'(out_data), int'(m_data));
        chk("primed", int'(primed), int'(m_cnt > 0 && sc >= m_d));
        chk("delay_active", int'(delay_active), m_d);
        if (out_valid) outs.push_back(out_data);
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic ld, input logic [7:0] dl,
                     input logic fl);
    in_valid = v; in_data = d;
    delay_load = ld; delay_in = dl; flush = fl;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic load(input logic [7:0] dl);
    cyc(1'b0, 8'd0, 1'b1, dl, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 0; delay_load = 0; flush = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_delay", int'(delay_active), 0);
    @(negedge clk);
    rst = 1'b0;
    outs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e1[10];
    e1 = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6};
    rst = 1'b1;
    in_valid = 0; in_data = 0; delay_load = 0; delay_in = 0; flush = 0;
    @(negedge clk);
    do_reset();

    // Delay 4, samples 1..10.
    load(8'd4);
    chk("t1_state_idle", int'(state), 0);
    for (int k = 1; k <= 10; k++) begin
      strobe(8'(k));
      if (k == 1) chk("t1_state_s1", int'(state), 1);
      if (k == 4) chk("t1_state_s4", int'(state), 1);
      if (k == 5) chk("t1_state_s5", int'(state), 2);
    end
    idle();
    chk("t1_count", outs.size(), 10);
    for (int i = 0; i < 10 && i < outs.size(); i++)
      chk($sformatf("t1_out%0d", i), int'(outs[i]), e1[i]);

    // Delay 0 bypass.
    do_reset();
    load(8'd0);
    strobe(8'h5A);
    chk("t2_primed1", int'(primed), 1);
    strobe(8'hA5);
    chk("t2_primed2", int'(primed), 1);
    idle();
    chk("t2_count", outs.size(), 2);
    if (outs.size() == 2) begin
      chk("t2_out0", int'(outs[0]), 'h5A);
      chk("t2_out1", int'(outs[1]), 'hA5);
    end

    // Delay 255, 300 samples, address wrap.
    do_reset();
    load(8'd255);
    for (int k = 0; k < 300; k++) strobe(8'(k));
    idle();
    chk("t3_count", outs.size(), 300);
    if (outs.size() == 300) begin
      chk("t3_out254", int'(outs[254]), 0);
      chk("t3_out256", int'(outs[256]), 1);
      chk("t3_out299", int'(outs[299]), 44);
    end

    // Delay raised above fill count while running.
    do_reset();
    load(8'd3);
    for (int k = 0; k < 10; k++) strobe(8'(10 + k));
    idle();
    chk("t4_state_run", int'(state), 2);
    load(8'd20);
    chk("t4_state_fill", int'(state), 1);
    chk("t4_delay", int'(delay_active), 20);
    outs.delete();
    for (int k = 0; k < 12; k++) strobe(8'(100 + k));
    idle();
    chk("t4_state_end", int'(state), 2);
    chk("t4_count", outs.size(), 12);
    if (outs.size() == 12) begin
      chk("t4_out9", int'(outs[9]), 0);
      chk("t4_out10", int'(outs[10]), 10);
      chk("t4_out11", int'(outs[11]), 11);
    end

    // Flush coinciding with a strobe, delay 2.
    do_reset();
    load(8'd2);
    for (int k = 1; k <= 5; k++) strobe(8'(k));
    chk("t5_state_run", int'(state), 2);
    idle();
    outs.delete();
    cyc(1'b1, 8'h77, 1'b0, 8'd0, 1'b1);
    chk("t5_state_empty", int'(state), 0);
    strobe(8'h78);
    chk("t5_state_fill", int'(state), 1);
    strobe(8'h79);
    chk("t5_state_run2", int'(state), 2);
    idle();
    chk("t5_count", outs.size(), 3);
    if (outs.size() == 3) begin
      chk("t5_out0", int'(outs[0]), 0);
      chk("t5_out1", int'(outs[1]), 0);
      chk("t5_out2", int'(outs[2]), 'h77);
    end

    // Reset mid-stream with an output pending, then delay 0 passthrough.
    strobe(8'h11);
    do_reset();
    strobe(8'h33);
    idle();
    chk("t6_count", outs.size(), 1);
    if (outs.size() == 1) chk("t6_out0", int'(outs[0]), 'h33);

`ifdef SIGDELAY_ECHO_EN
    do_reset();
    load(8'd1);
    strobe(8'd100);
    strobe(8'd100);
    idle();
    if (outs.size() == 2) begin
      chk("t7_out0", int'(outs[0]), 100);
      chk("t7_out1", int'(outs[1]), 127);
    end
    do_reset();
    load(8'd1);
    strobe(8'(-100));
    strobe(8'(-100));
    idle();
    if (outs.size() == 2) begin
      chk("t7_out2", int'($signed(outs[0])), -100);
      chk("t7_out3", int'($signed(outs[1])), -128);
    end
`endif

    idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
